// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   TOHOST_OFF / CYCLE_OFF : MMIO register offsets inside the 16-byte window
//   access_legal()         : accepts only naturally aligned byte_en/offset pairs
//   lane_mask()            : expands a 4-bit lane enable into a 32-bit bit mask
package dmem_pkg;

    localparam logic [3:0] TOHOST_OFF = 4'h0;
    localparam logic [3:0] CYCLE_OFF  = 4'h4;

    // Words at offset 0, halfwords at offset 0 or 2, bytes at their own lane.
    // Everything else, including an all-zero enable, is illegal.
    function automatic logic access_legal(input logic [3:0] be, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (be)
            4'b1111, 4'b0011: ok = (off == 2'd0);
            4'b1100:          ok = (off == 2'd2);
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: ok = (be == (4'b0001 << off));
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/data_memory_read_delay_pipe.sv
// Fixed-latency valid/data delay line for load responses.
//   clk         : clock
//   flush_n     : synchronous active-low flush; clears every stage
//   in_valid_i  : read accepted this cycle
//   in_data_i   : word sampled at the request edge
//   out_valid_o : one-cycle pulse READ_LATENCY cycles after the request
//   out_data_o  : last delivered word; holds between pulses
module read_delay_pipe #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        flush_n,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o
);

    // Index 0 is the combinational input; 1..READ_LATENCY are registers.
    logic [READ_LATENCY:0]       vld_pipe;
    logic [READ_LATENCY:0][31:0] dat_pipe;
    logic [READ_LATENCY:1]       vld_q;
    logic [READ_LATENCY:1][31:0] dat_q;

    assign vld_pipe = {vld_q, in_valid_i};
    assign dat_pipe = {dat_q, in_data_i};

    // Data only advances behind a valid bit, so the last stage naturally
    // keeps the most recent delivered word between pulses.
    always_ff @(posedge clk) begin
        if (!flush_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_pipe[READ_LATENCY-1:0];
            for (int s = 1; s <= int'(READ_LATENCY); s++) begin
                if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
            end
        end
    end

    assign out_valid_o = vld_q[READ_LATENCY];
    assign out_data_o  = dat_q[READ_LATENCY];

endmodule

// File: rtl/data_memory.sv
// Data-memory responder: byte-lane RAM plus a small MMIO window.
//   clk, rst          : clock, synchronous active-low reset
//   read, write       : request strobes
//   byte_en, daddr    : lane enables and byte address
//   write_data        : lane-aligned store data
//   read_data         : load data, valid with read_valid, held otherwise
//   read_valid        : one pulse per accepted read, READ_LATENCY cycles later
//   misaligned        : sticky illegal-access flag
//   halt, halt_code   : sticky TOHOST flag and the value that set it
module data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byte_en,
    input  logic [31:0] daddr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        misaligned,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          halt_q, halt_d;
    logic          misaligned_q, misaligned_d;
    logic [31:0]   halt_code_q, halt_code_d;
    logic [31:0]   cycle_q, cycle_d;

    logic          sel_mmio, legal, ram_we, tohost_we;
    logic [AW-1:0] word_idx;
    logic [31:0]   be_mask, rd_raw, rd_word;

    // Upper address bits above the RAM index are ignored, so RAM aliases.
    assign sel_mmio  = (daddr[31:4] == MMIO_BASE[31:4]);
    assign legal     = access_legal(byte_en, daddr[1:0]);
    assign word_idx  = daddr[AW+1:2];
    assign be_mask   = lane_mask(byte_en);
    // Once halted, memory is frozen so the final image can be compared.
    assign ram_we    = rst && write && legal && !halt_q && !sel_mmio;
    assign tohost_we = write && legal && sel_mmio && !halt_q &&
                       (daddr[3:2] == TOHOST_OFF[3:2]) && (byte_en == 4'hF);

    always_comb begin
        halt_d       = halt_q;
        halt_code_d  = halt_code_q;
        misaligned_d = misaligned_q;
        cycle_d      = cycle_q + 32'd1;
        if ((read || write) && !legal) misaligned_d = 1'b1;
        if (tohost_we) begin
            halt_d      = 1'b1;
            halt_code_d = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            halt_q       <= 1'b0;
            halt_code_q  <= '0;
            misaligned_q <= 1'b0;
            cycle_q      <= '0;
        end else begin
            halt_q       <= halt_d;
            halt_code_q  <= halt_code_d;
            misaligned_q <= misaligned_d;
            cycle_q      <= cycle_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    // Read-first: everything here sees pre-edge state, so a same-cycle
    // write (RAM or TOHOST) is not visible to the read.
    always_comb begin
        rd_raw = '0;
        if (sel_mmio) begin
            case ({daddr[3:2], 2'b00})
                TOHOST_OFF: rd_raw = halt_code_q;
                CYCLE_OFF:  rd_raw = cycle_q;
                default:    rd_raw = '0;
            endcase
        end else begin
            rd_raw = mem_q[word_idx];
        end
        rd_word = legal ? (rd_raw & be_mask) : '0;
    end

    read_delay_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk         (clk),
        .flush_n     (rst),
        .in_valid_i  (read),
        .in_data_i   (rd_word),
        .out_valid_o (read_valid),
        .out_data_o  (read_data)
    );

    assign halt       = halt_q;
    assign halt_code  = halt_code_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    localparam logic [31:0] MB = 32'hFFFF_0000;
    localparam int LAT [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        read, write;
    logic [3:0]  byte_en;
    logic [31:0] daddr, write_data;
    logic [31:0] rdata [3];
    logic [31:0] hc [3];
    logic        rv [3];
    logic        mis [3];
    logic        hl [3];

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .MMIO_BASE(MB)) u1 (
        .clk(clk), .rst(rst), .read(read), .write(write), .byte_en(byte_en),
        .daddr(daddr), .write_data(write_data), .read_data(rdata[0]),
        .read_valid(rv[0]), .misaligned(mis[0]), .halt(hl[0]), .halt_code(hc[0]));
    data_memory #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .MMIO_BASE(MB)) u3 (
        .clk(clk), .rst(rst), .read(read), .write(write), .byte_en(byte_en),
        .daddr(daddr), .write_data(write_data), .read_data(rdata[1]),
        .read_valid(rv[1]), .misaligned(mis[1]), .halt(hl[1]), .halt_code(hc[1]));
    data_memory #(.DEPTH_WORDS(1024), .READ_LATENCY(4), .MMIO_BASE(MB)) u4 (
        .clk(clk), .rst(rst), .read(read), .write(write), .byte_en(byte_en),
        .daddr(daddr), .write_data(write_data), .read_data(rdata[2]),
        .read_valid(rv[2]), .misaligned(mis[2]), .halt(hl[2]), .halt_code(hc[2]));

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [1024];
    bit          m_halt, m_mis;
    logic [31:0] m_code, m_cyc;
    bit          pv [3][5];
    logic [31:0] pd [3][5];
    bit          ev [3];
    logic [31:0] ed [3];
    bit          m_lg, m_io;
    logic [31:0] m_word, m_rw;

    function automatic bit legal_f(input logic [3:0] be, input logic [1:0] off);
        logic [3:0] one;
        one = 4'b0001 << off;
        return (be == 4'hF && off == 0) || (be == 4'h3 && off == 0) ||
               (be == 4'hC && off == 2) || (be == one);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_halt = 0; m_mis = 0; m_code = 0; m_cyc = 0;
            for (int d = 0; d < 3; d++) begin
                for (int s = 0; s < 5; s++) begin pv[d][s] = 0; pd[d][s] = 0; end
                ev[d] = 0; ed[d] = 0;
            end
        end else begin
            m_lg = legal_f(byte_en, daddr[1:0]);
            m_io = (daddr[31:4] == MB[31:4]);
            m_rw = 0;
            if (read && m_lg) begin
                if (m_io) m_word = (daddr[3:2] == 0) ? m_code : (daddr[3:2] == 1) ? m_cyc : 32'd0;
                else      m_word = m_mem[daddr[11:2]];
                for (int b = 0; b < 4; b++) if (byte_en[b]) m_rw[8*b +: 8] = m_word[8*b +: 8];
            end
            if ((read || write) && !m_lg) m_mis = 1;
            if (write && m_lg && !m_halt) begin
                if (m_io) begin
                    if (daddr[3:2] == 0 && byte_en == 4'hF) begin m_halt = 1; m_code = write_data; end
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (byte_en[b]) m_mem[daddr[11:2]][8*b +: 8] = write_data[8*b +: 8];
                end
            end
            m_cyc = m_cyc + 1;
            for (int d = 0; d < 3; d++) begin
                for (int s = LAT[d]; s >= 2; s--) begin pv[d][s] = pv[d][s-1]; pd[d][s] = pd[d][s-1]; end
                pv[d][1] = read; pd[d][1] = m_rw;
                ev[d] = pv[d][LAT[d]];
                if (ev[d]) ed[d] = pd[d][LAT[d]];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("L%0d read_valid", LAT[d]), 32'(rv[d]), 32'(ev[d]));
                check($sformatf("L%0d read_data", LAT[d]), rdata[d], ed[d]);
                check($sformatf("L%0d misaligned", LAT[d]), 32'(mis[d]), 32'(m_mis));
                check($sformatf("L%0d halt", LAT[d]), 32'(hl[d]), 32'(m_halt));
                check($sformatf("L%0d halt_code", LAT[d]), hc[d], m_code);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic r, input logic w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
        read = r; write = w; byte_en = be; daddr = a; write_data = wd;
        @(negedge clk);
        read = 0; write = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 0; read = 0; write = 0; byte_en = 0; daddr = 0; write_data = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("reset read_data", rdata[0], 32'h0);
        check("reset read_valid", 32'(rv[0]), 32'h0);
        check("reset misaligned", 32'(mis[0]), 32'h0);
        check("reset halt", 32'(hl[0]), 32'h0);
        check("reset halt_code", hc[0], 32'h0);
        rst = 1;

        // cycle counter: read at the 11th edge after release sees 10
        repeat (10) idle();
        cyc(1, 0, 4'hF, MB + 32'h4, 0);
        check("cycle read valid", 32'(rv[0]), 32'h1);
        check("cycle read value", rdata[0], 32'd10);

        // store word then load, latency 1
        cyc(0, 1, 4'hF, 32'h100, 32'hDEADBEEF);
        check("no valid on store", 32'(rv[0]), 32'h0);
        cyc(1, 0, 4'hF, 32'h100, 0);
        check("load valid L1", 32'(rv[0]), 32'h1);
        check("load data L1", rdata[0], 32'hDEADBEEF);
        idle();
        check("single pulse L1", 32'(rv[0]), 32'h0);
        check("data held L1", rdata[0], 32'hDEADBEEF);

        // byte merge, partial reads, misaligned store, aliasing
        cyc(0, 1, 4'hF, 32'h100, 32'h11223344);
        cyc(0, 1, 4'b0010, 32'h101, 32'h0000AA00);
        cyc(1, 0, 4'hF, 32'h100, 0);
        check("byte merge", rdata[0], 32'h1122AA44);
        cyc(0, 1, 4'b0011, 32'h101, 32'h0000FFFF);
        check("misaligned set", 32'(mis[0]), 32'h1);
        cyc(1, 0, 4'hF, 32'h100, 0);
        check("misaligned store dropped", rdata[0], 32'h1122AA44);
        cyc(1, 0, 4'b0100, 32'h102, 0);
        check("byte read lane2", rdata[0], 32'h00220000);
        cyc(1, 0, 4'b1100, 32'h102, 0);
        check("half read upper", rdata[0], 32'h11220000);
        cyc(1, 0, 4'b0011, 32'h101, 0);
        check("illegal read valid", 32'(rv[0]), 32'h1);
        check("illegal read zero", rdata[0], 32'h0);
        cyc(1, 0, 4'hF, 32'h1100, 0);
        check("alias read", rdata[0], 32'h1122AA44);

        // back-to-back reads at latency 3
        cyc(0, 1, 4'hF, 32'h0, 32'hA0A0A0A0);
        cyc(0, 1, 4'hF, 32'h4, 32'hA4A4A4A4);
        cyc(0, 1, 4'hF, 32'h8, 32'hA8A8A8A8);
        cyc(1, 0, 4'hF, 32'h0, 0);
        cyc(1, 0, 4'hF, 32'h4, 0);
        check("L3 not yet valid", 32'(rv[1]), 32'h0);
        cyc(1, 0, 4'hF, 32'h8, 0);
        check("L3 first valid", 32'(rv[1]), 32'h1);
        check("L3 first data", rdata[1], 32'hA0A0A0A0);
        idle();
        check("L3 second data", rdata[1], 32'hA4A4A4A4);
        idle();
        check("L3 third valid", 32'(rv[1]), 32'h1);
        check("L3 third data", rdata[1], 32'hA8A8A8A8);
        idle();
        check("L3 pulses end", 32'(rv[1]), 32'h0);

        // same-cycle read/write is read-first
        cyc(0, 1, 4'hF, 32'h20, 32'd5);
        cyc(1, 1, 4'hF, 32'h20, 32'd9);
        check("read-first old", rdata[0], 32'd5);
        cyc(1, 0, 4'hF, 32'h20, 0);
        check("read-first new", rdata[0], 32'd9);

        // TOHOST halt freezes RAM and halt_code
        cyc(0, 1, 4'hF, 32'h40, 32'h1234);
        cyc(0, 1, 4'hF, MB, 32'h1);
        check("halt set", 32'(hl[0]), 32'h1);
        check("halt code", hc[0], 32'h1);
        cyc(0, 1, 4'hF, 32'h40, 32'h77);
        cyc(0, 1, 4'hF, MB, 32'h2);
        check("halt code first wins", hc[0], 32'h1);
        cyc(1, 0, 4'hF, 32'h40, 0);
        check("ram frozen", rdata[0], 32'h1234);
        cyc(1, 0, 4'hF, MB, 0);
        check("tohost readback", rdata[0], 32'h1);
        cyc(1, 0, 4'hF, MB + 32'h8, 0);
        check("mmio 0x8 reads zero", rdata[0], 32'h0);

        // reset flushes an in-flight latency-4 read
        cyc(1, 0, 4'hF, 32'h0, 0);
        idle();
        rst = 0;
        @(negedge clk);
        check("flush L4 valid", 32'(rv[2]), 32'h0);
        check("flush L4 data", rdata[2], 32'h0);
        check("flush misaligned", 32'(mis[2]), 32'h0);
        check("flush halt", 32'(hl[2]), 32'h0);
        check("flush halt_code", hc[2], 32'h0);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("no late L4 pulse", 32'(rv[2]), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
